// File: rtl/uart_program_loader_pkg.sv
// Shared types for the boot-time UART program loader.
// MEM_WORD_WRITE must track the core's mem_write_size encoding.
package uart_program_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_WAIT_WR,
        S_CHECK,
        S_DONE,
        S_ERROR
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_FRAMING  = 3'd1;
    localparam logic [2:0] ERR_OVERRUN  = 3'd2;
    localparam logic [2:0] ERR_LENGTH   = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
    localparam logic [2:0] ERR_CHECKSUM = 3'd5;

    localparam logic [1:0] MEM_WORD_WRITE = 2'b11;
    localparam logic [1:0] MEM_NO_WRITE   = 2'b00;

    function automatic logic [31:0] word_addr(
        input logic [31:0] base,
        input logic [15:0] idx
    );
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Memory write port between the loader (master) and the RAM (slave).
interface uart_program_loader_if;

    logic [31:0] mem_address;
    logic [31:0] mem_write_word;
    logic [1:0]  mem_write_mode;
    logic        mem_done;

    modport master (
        output mem_address,
        output mem_write_word,
        output mem_write_mode,
        input  mem_done
    );

    modport slave (
        input  mem_address,
        input  mem_write_word,
        input  mem_write_mode,
        output mem_done
    );

endinterface

// File: rtl/uart_program_loader_uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling,
// one-cycle byte_valid or frame_err at the middle of the stop bit.
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    rx_state_t      state, state_nx;
    logic           rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           half_tick, full_tick;

    assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
    assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));
    assign data      = shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RX_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            RX_IDLE:  if (rx_prev && !rx_sync) state_nx = RX_START;
            RX_START: if (half_tick) state_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick && bit_idx == 3'd7) state_nx = RX_STOP;
            RX_STOP:  if (full_tick) state_nx = RX_IDLE;
            default:  state_nx = RX_IDLE;
        endcase
    end

    // Counter restarts on every state change so DATA ticks land mid-bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (state == RX_IDLE || state != state_nx || full_tick)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
            if (state == RX_IDLE)
                bit_idx <= '0;
            else if (state == RX_DATA && full_tick) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state == RX_STOP && full_tick) begin
            byte_valid = rx_sync;
            frame_err  = !rx_sync;
        end
    end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: length-prefixed image over UART, written word by word
// into memory, closed by an XOR checksum byte.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int          CLK_HZ         = 50_000_000,
    parameter int          BAUD           = 115_200,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          MAX_WORDS      = 32768,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    input  logic                         arm,
    uart_program_loader_if.master        mem,
    output logic                         busy,
    output logic                         load_complete,
    output logic                         load_error,
    output logic [2:0]                   error_code,
    output logic [15:0]                  words_loaded
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ld_state_t     state, state_nx;
    logic [7:0]    rx_byte, hold_byte, csum;
    logic          rx_valid, rx_ferr, hold_full;
    logic [1:0]    byte_idx;
    logic [31:0]   len, asm_word, len_nx, word_nx;
    logic [TW-1:0] timer;
    logic          consume, in_session, overrun, timeout, last_word;
    logic [2:0]    err_nx;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .data       (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    assign in_session = state inside {S_LEN, S_DATA, S_WRITE,
                                      S_WAIT_WR, S_CHECK};
    assign consume    = hold_full && (state inside {S_LEN, S_DATA, S_CHECK});
    assign overrun    = rx_valid && hold_full && !consume;
    assign timeout    = state == S_WAIT_WR && !mem.mem_done
                     && timer == TW'(TIMEOUT_CYCLES - 1);
    assign len_nx     = {hold_byte, len[31:8]};
    assign word_nx    = {hold_byte, asm_word[31:8]};
    assign last_word  = ({16'd0, words_loaded} + 32'd1) >= len;

    always_comb begin
        err_nx = ERR_NONE;
        if (in_session) begin
            if (rx_ferr)
                err_nx = ERR_FRAMING;
            else if (overrun)
                err_nx = ERR_OVERRUN;
            else if (timeout)
                err_nx = ERR_TIMEOUT;
            else if (consume && state == S_LEN && byte_idx == 2'd3
                     && len_nx > 32'(MAX_WORDS))
                err_nx = ERR_LENGTH;
            else if (consume && state == S_CHECK && hold_byte != csum)
                err_nx = ERR_CHECKSUM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (err_nx != ERR_NONE)
            state_nx = S_ERROR;
        else begin
            unique case (state)
                S_IDLE:    if (arm) state_nx = S_LEN;
                S_LEN:     if (consume && byte_idx == 2'd3)
                               state_nx = (len_nx == 32'd0) ? S_CHECK : S_DATA;
                S_DATA:    if (consume && byte_idx == 2'd3) state_nx = S_WRITE;
                S_WRITE:   state_nx = S_WAIT_WR;
                S_WAIT_WR: if (mem.mem_done)
                               state_nx = last_word ? S_CHECK : S_DATA;
                S_CHECK:   if (consume) state_nx = S_DONE;
                default:   state_nx = state;
            endcase
        end
    end

    // Bytes landing during WRITE/WAIT_WR stay parked until DATA/CHECK
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_byte     <= '0;
            hold_full     <= 1'b0;
            byte_idx      <= '0;
            csum          <= '0;
            len           <= '0;
            asm_word      <= '0;
            timer         <= '0;
            words_loaded  <= '0;
            load_complete <= 1'b0;
            load_error    <= 1'b0;
            error_code    <= ERR_NONE;
        end else begin
            if (rx_valid && in_session)
                hold_byte <= rx_byte;
            hold_full <= (rx_valid && in_session) || (hold_full && !consume);
            if (state == S_IDLE) begin
                byte_idx     <= '0;
                csum         <= '0;
                words_loaded <= '0;
            end
            if (consume && state != S_CHECK)
                byte_idx <= byte_idx + 2'd1;
            if (consume && state == S_LEN)
                len <= len_nx;
            if (consume && state == S_DATA) begin
                asm_word <= word_nx;
                csum     <= csum ^ hold_byte;
            end
            timer <= (state == S_WAIT_WR) ? timer + TW'(1) : '0;
            if (state == S_WAIT_WR && mem.mem_done && err_nx == ERR_NONE
                && words_loaded != 16'hFFFF)
                words_loaded <= words_loaded + 16'd1;
            if (err_nx != ERR_NONE) begin
                load_error <= 1'b1;
                error_code <= err_nx;
            end
            if (state == S_CHECK && consume && err_nx == ERR_NONE)
                load_complete <= 1'b1;
        end
    end

    always_comb begin
        busy               = !(state inside {S_IDLE, S_DONE, S_ERROR});
        mem.mem_address    = '0;
        mem.mem_write_word = '0;
        mem.mem_write_mode = MEM_NO_WRITE;
        if (state == S_WRITE || state == S_WAIT_WR) begin
            mem.mem_address    = word_addr(BASE_ADDR, words_loaded);
            mem.mem_write_word = asm_word;
            mem.mem_write_mode = MEM_WORD_WRITE;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed + randomized bench for uart_program_loader with a
// frame-level reference model and a latency-randomized memory.
module tb_uart_program_loader;

    localparam int CPB  = 16;
    localparam int MAXW = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        arm;
    logic        busy, load_complete, load_error;
    logic [2:0]  error_code;
    logic [15:0] words_loaded;

    uart_program_loader_if mif ();

    uart_program_loader #(
        .CLK_HZ (16),
        .BAUD   (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .arm           (arm),
        .mem           (mif),
        .busy          (busy),
        .load_complete (load_complete),
        .load_error    (load_error),
        .error_code    (error_code),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] words_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          unstable  = 0;
    bit          stall     = 1'b0;
    bit          wr_seen   = 1'b0;
    bit          done_sent = 1'b0;
    int          lat, age;
    int          wr_t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: logs each write, checks hold-stability, random latency
    always @(negedge clk) begin
        if (mif.mem_write_mode == 2'b11) begin
            if (!wr_seen) begin
                wr_seen = 1'b1;
                wr_addr_q.push_back(mif.mem_address);
                wr_data_q.push_back(mif.mem_write_word);
                lat   = $urandom_range(1, 6);
                age   = 0;
                wr_t0 = cyc;
            end else if (mif.mem_address !== wr_addr_q[$]
                      || mif.mem_write_word !== wr_data_q[$])
                unstable++;
            age++;
            mif.mem_done = !stall && !done_sent && age > lat;
            if (mif.mem_done) done_sent = 1'b1;
        end else begin
            wr_seen      = 1'b0;
            done_sent    = 1'b0;
            mif.mem_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_csum();
        logic [7:0] c;
        c = 8'h00;
        foreach (words_q[i])
            c ^= words_q[i][7:0] ^ words_q[i][15:8]
               ^ words_q[i][23:16] ^ words_q[i][31:24];
        return c;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic send_frame(input logic [31:0] n, input logic [7:0] flip);
        send_word(n);
        if (n <= MAXW) begin
            foreach (words_q[i]) send_word(words_q[i]);
            send_byte(model_csum() ^ flip);
        end
    endtask

    task automatic do_reset();
        rst  = 1'b0;
        arm  = 1'b0;
        rx   = 1'b1;
        stall = 1'b0;
        repeat (3) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        unstable = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    task automatic wait_terminal(input string tag);
        int n;
        n = 0;
        while (!(load_complete || load_error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".terminal"}, load_complete || load_error, 1);
    endtask

    task automatic check_result(input string tag, input logic [2:0] code,
                                input int nw);
        wait_terminal(tag);
        repeat (4) @(negedge clk);
        chk({tag, ".complete"}, load_complete, code == 3'd0);
        chk({tag, ".error"}, load_error, code != 3'd0);
        chk({tag, ".code"}, error_code, code);
        chk({tag, ".words"}, words_loaded, nw);
        chk({tag, ".nwrites"}, wr_addr_q.size(), nw);
        for (int i = 0; i < nw && i < wr_addr_q.size(); i++) begin
            chk({tag, ".addr"}, wr_addr_q[i], i * 4);
            chk({tag, ".data"}, wr_data_q[i], words_q[i]);
        end
        chk({tag, ".stable"}, unstable, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".mode"}, mif.mem_write_mode, 2'b00);
    endtask

    initial begin
        int n, el;
        mif.mem_done = 1'b0;

        // Reset state and quiet idle
        do_reset();
        chk("rst.busy", busy, 0);
        chk("rst.complete", load_complete, 0);
        chk("rst.error", load_error, 0);
        chk("rst.code", error_code, 0);
        chk("rst.words", words_loaded, 0);
        chk("rst.addr", mif.mem_address, 0);
        chk("rst.word", mif.mem_write_word, 0);
        repeat (10000) @(negedge clk);
        chk("idle.nwrites", wr_addr_q.size(), 0);
        chk("idle.busy", busy, 0);

        // Two-word image
        do_reset();
        arm = 1'b1;
        words_q = '{32'h0000_0013, 32'hDEAD_BEEF};
        send_frame(2, 8'h00);
        check_result("two_words", 3'd0, 2);
        send_byte(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        chk("done.ignore_err", load_error, 0);
        chk("done.ignore_cpl", load_complete, 1);

        // Empty image, good and bad checksum
        do_reset();
        arm = 1'b1;
        words_q.delete();
        send_frame(0, 8'h00);
        check_result("empty_ok", 3'd0, 0);
        do_reset();
        arm = 1'b1;
        send_frame(0, 8'h01);
        check_result("empty_bad", 3'd5, 0);

        // Oversized length
        do_reset();
        arm = 1'b1;
        send_frame(32'h0000_8001, 8'h00);
        check_result("too_long", 3'd3, 0);

        // Random images, clean and corrupted checksum
        do_reset();
        arm = 1'b1;
        n = $urandom_range(1, 6);
        rand_words(n);
        send_frame(n, 8'h00);
        check_result("rand_ok", 3'd0, n);
        do_reset();
        arm = 1'b1;
        n = $urandom_range(1, 4);
        rand_words(n);
        send_frame(n, 8'h00 | 8'($urandom_range(1, 255)));
        check_result("rand_bad", 3'd5, n);

        // Memory never acknowledges
        do_reset();
        arm   = 1'b1;
        stall = 1'b1;
        rand_words(1);
        send_word(1);
        send_word(words_q[0]);
        n = 0;
        while (cyc < wr_t0 + 1000 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("timeout.early", load_error, 0);
        n = 0;
        while (!load_error && n < 200) begin
            @(negedge clk);
            n++;
        end
        el = cyc - wr_t0;
        chk("timeout.window", el >= 1020 && el <= 1030, 1);
        chk("timeout.code", error_code, 3'd4);
        chk("timeout.mode", mif.mem_write_mode, 2'b00);
        chk("timeout.words", words_loaded, 0);

        // Bad stop bit on a data byte
        do_reset();
        arm = 1'b1;
        words_q.delete();
        send_word(1);
        send_byte(8'hA5, 1'b0);
        check_result("framing", 3'd1, 0);

        // Reset in the middle of word 3 of 5, arm left high
        do_reset();
        arm = 1'b1;
        rand_words(5);
        send_word(5);
        send_word(words_q[0]);
        send_word(words_q[1]);
        send_byte(words_q[2][7:0]);
        send_byte(words_q[2][15:8]);
        chk("mid.words_before", words_loaded, 2);
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid.busy", busy, 0);
        chk("mid.words", words_loaded, 0);
        chk("mid.mode", mif.mem_write_mode, 2'b00);
        chk("mid.addr", mif.mem_address, 0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        unstable = 0;
        rst = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        rand_words(5);
        send_frame(5, 8'h00);
        check_result("reload", 3'd0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
